keypad_digit_register: RTL and testbench

- Receive side of the keypad encoder interface: consumes the 4-bit digit bus `D` and the key-active strobe `loadn`.
- Synchronises and debounces the strobe, then accepts exactly one digit per key press.
- Shifts accepted digits into a 4-digit BCD MM:SS entry register that feeds the microwave timer loader and display.
- Entry is blocked while `lock` is high (cooking in progress).

---
 rtl/keypad_digit_register_pkg.sv | 23 ++
 rtl/keypad_digit_register_if.sv | 14 +
 rtl/keypad_digit_register_key_debouncer.sv | 110 +++++++++++
 rtl/keypad_digit_register.sv | 108 ++++++++++
 tb/tb_keypad_digit_register.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_digit_register_pkg.sv
// keypad_pkg: shared types and constants for the keypad digit register slice.
//   - kp_state_e : key debouncer FSM state encoding (2 bits)
//   - DIGIT_W, MAX_DIGIT_VAL, MAX_DIGITS : BCD entry geometry
//   - is_decimal(): true when a keypad code is a legal BCD digit (0..9)
package keypad_pkg;

  localparam int DIGIT_W       = 4;
  localparam int MAX_DIGIT_VAL = 9;
  localparam int MAX_DIGITS    = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PRESS_DB   = 2'b01,
    HELD       = 2'b10,
    RELEASE_DB = 2'b11
  } kp_state_e;

  // Keypad codes above 9 are not digits and must never enter the register.
  function automatic logic is_decimal(input logic [DIGIT_W-1:0] d);
    return (d <= 4'(MAX_DIGIT_VAL));
  endfunction

endpackage

// File: rtl/keypad_digit_register_if.sv
// keypad_digit_register_if: keypad encoder -> digit register link.
//   D     : 4-bit digit code, stable while a key is held
//   loadn : key-active strobe, high while any key is pressed, asynchronous
// Modports: master = encoder side (drives), slave = register side (receives).
interface keypad_digit_register_if;
  import keypad_pkg::*;

  logic [DIGIT_W-1:0] D;
  logic               loadn;

  modport master (output D, output loadn);
  modport slave  (input  D, input  loadn);

endinterface

// File: rtl/keypad_digit_register_key_debouncer.sv
// key_debouncer: synchronises the keypad strobe and debounces press/release.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   loadn      : raw key-active strobe (asynchronous to clk)
//   press_evt  : one-cycle pulse in the cycle a press is accepted
// A held key yields a single press_evt; a release must itself be stable for
// DEBOUNCE_CYCLES before the next press can be recognised.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic loadn,
  output logic press_evt
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES);

  logic      sync1_r;
  logic      key_s;
  kp_state_e state_r;
  kp_state_e state_n;
  logic [7:0] cnt_r;
  logic [7:0] cnt_n;
  logic       press_evt_s;

  // Two-flop synchroniser for the asynchronous strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      key_s   <= 1'b0;
    end else begin
      sync1_r <= loadn;
      key_s   <= sync1_r;
    end
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state logic; the counter is loaded with 1 on entry to a debounce
  // state so the entry cycle counts as the first stable cycle.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    press_evt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_s) begin
          state_n = PRESS_DB;
          cnt_n   = 8'd1;
        end else begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end
      end
      PRESS_DB: begin
        if (!key_s) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else if (cnt_r >= DB_LAST) begin
          press_evt_s = 1'b1;
          state_n     = HELD;
          cnt_n       = 8'd0;
        end else begin
          state_n = PRESS_DB;
          cnt_n   = cnt_r + 8'd1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_n = RELEASE_DB;
          cnt_n   = 8'd1;
        end else begin
          state_n = HELD;
          cnt_n   = 8'd0;
        end
      end
      RELEASE_DB: begin
        if (key_s) begin
          state_n = HELD;
          cnt_n   = 8'd0;
        end else if (cnt_r >= DB_LAST) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          state_n = RELEASE_DB;
          cnt_n   = cnt_r + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  assign press_evt = press_evt_s;

endmodule

// File: rtl/keypad_digit_register.sv
// keypad_digit_register: debounced keypad entry into a 4-digit BCD MM:SS
// register feeding the microwave timer loader and display.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   kp           : keypad link (D digit code, loadn key strobe), slave side
//   clear        : synchronous clear of digits and count (wins over accept)
//   lock         : entry inhibited; presses are debounced then discarded
//   min_tens..sec_ones : BCD digits, MSD to LSD
//   digit_count  : digits accepted since reset/clear (0..4)
//   digit_stb    : one-cycle pulse per accepted digit
//   entry_valid  : any held digit nonzero
// Build option: define ENTRY_ROLLOVER_EN to keep shifting once full
// (oldest digit dropped, count stays at 4).
module keypad_digit_register
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  keypad_digit_register_if.slave  kp,
  input  logic                    clear,
  input  logic                    lock,
  output logic [DIGIT_W-1:0]      min_tens,
  output logic [DIGIT_W-1:0]      min_ones,
  output logic [DIGIT_W-1:0]      sec_tens,
  output logic [DIGIT_W-1:0]      sec_ones,
  output logic [2:0]              digit_count,
  output logic                    digit_stb,
  output logic                    entry_valid
);

  localparam logic [2:0] COUNT_FULL = 3'(MAX_DIGITS);

  logic        press_evt_s;
  logic        room_s;
  logic        accept_s;
  logic [15:0] digits_r;
  logic [15:0] digits_n;
  logic [2:0]  count_r;
  logic [2:0]  count_n;
  logic        stb_r;
  logic        stb_n;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst       (rst),
    .loadn     (kp.loadn),
    .press_evt (press_evt_s)
  );

`ifdef ENTRY_ROLLOVER_EN
  assign room_s = 1'b1;
`else
  assign room_s = (count_r < COUNT_FULL);
`endif

  // D is sampled raw here: the debounce window guarantees it has settled.
  assign accept_s = press_evt_s && !lock && is_decimal(kp.D) && room_s;

  // Shift-register / count next-state; clear overrides a same-cycle accept.
  always_comb begin
    digits_n = digits_r;
    count_n  = count_r;
    stb_n    = 1'b0;
    if (clear) begin
      digits_n = 16'h0000;
      count_n  = 3'd0;
      stb_n    = 1'b0;
    end else if (accept_s) begin
      digits_n = {digits_r[11:0], kp.D};
      stb_n    = 1'b1;
      if (count_r < COUNT_FULL) begin
        count_n = count_r + 3'd1;
      end else begin
        count_n = count_r;
      end
    end else begin
      digits_n = digits_r;
      count_n  = count_r;
      stb_n    = 1'b0;
    end
  end

  // Entry register, digit count and accept strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_r <= 16'h0000;
      count_r  <= 3'd0;
      stb_r    <= 1'b0;
    end else begin
      digits_r <= digits_n;
      count_r  <= count_n;
      stb_r    <= stb_n;
    end
  end

  assign min_tens    = digits_r[15:12];
  assign min_ones    = digits_r[11:8];
  assign sec_tens    = digits_r[7:4];
  assign sec_ones    = digits_r[3:0];
  assign digit_count = count_r;
  assign digit_stb   = stb_r;
  assign entry_valid = |digits_r;

endmodule

// File: tb/tb_keypad_digit_register.sv
// Directed bench for keypad_digit_register (DEBOUNCE_CYCLES = 4).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_keypad_digit_register;
  import keypad_pkg::*;

`ifdef ENTRY_ROLLOVER_EN
  localparam int RO = 1;
`else
  localparam int RO = 0;
`endif

  logic       clk;
  logic       rst;
  logic       clear;
  logic       lock;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [2:0] digit_count;
  logic       digit_stb;
  logic       entry_valid;
  logic [15:0] dig;

  int total;
  int bad;
  int stb_cnt;

  keypad_digit_register_if kp ();

  keypad_digit_register #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kp          (kp.slave),
    .clear       (clear),
    .lock        (lock),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .digit_count (digit_count),
    .digit_stb   (digit_stb),
    .entry_valid (entry_valid)
  );

  assign dig = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses seen on falling edges.
  always @(negedge clk) begin
    if (digit_stb === 1'b1) stb_cnt <= stb_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [3:0] d, input int hold, input int rel);
    kp.D     = d;
    kp.loadn = 1'b1;
    repeat (hold) @(negedge clk);
    kp.loadn = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    stb_cnt = 0;
    rst = 1'b1;
    clear = 1'b0;
    lock = 1'b0;
    kp.D = 4'd0;
    kp.loadn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_digits", dig, 16'h0000);
    check("rst_count", 16'(digit_count), 16'd0);
    check("rst_stb", 16'(digit_stb), 16'd0);
    check("rst_valid", 16'(entry_valid), 16'd0);

    // First press with latency check: strobe appears after edge 2+4+1 = 7
    kp.D = 4'd1;
    kp.loadn = 1'b1;
    repeat (6) @(negedge clk);
    check("lat_pre", 16'(digit_stb), 16'd0);
    @(negedge clk);
    check("lat_stb", 16'(digit_stb), 16'd1);
    check("lat_digit", dig, 16'h0001);
    repeat (3) @(negedge clk);
    kp.loadn = 1'b0;
    repeat (10) @(negedge clk);
    press_key(4'd2, 10, 10);
    press_key(4'd3, 10, 10);
    press_key(4'd0, 10, 10);
    check("seq_digits", dig, 16'h1230);
    check("seq_count", 16'(digit_count), 16'd4);
    check("seq_stbs", 16'(stb_cnt), 16'd4);
    check("seq_valid", 16'(entry_valid), 16'd1);

    pulse_clear();
    check("clr_digits", dig, 16'h0000);
    check("clr_count", 16'(digit_count), 16'd0);
    check("clr_valid", 16'(entry_valid), 16'd0);

    // Glitch shorter than the debounce window is ignored
    press_key(4'd7, 3, 10);
    check("glitch_stbs", 16'(stb_cnt), 16'd4);
    check("glitch_digits", dig, 16'h0000);

    // Release bounce: low 2, high 1, low 10 -> single accept
    kp.D = 4'd3;
    kp.loadn = 1'b1;
    repeat (10) @(negedge clk);
    kp.loadn = 1'b0;
    repeat (2) @(negedge clk);
    kp.loadn = 1'b1;
    @(negedge clk);
    kp.loadn = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_stbs", 16'(stb_cnt), 16'd5);
    check("bounce_digits", dig, 16'h0003);

    // Long hold gives one accept; lock discards; unlock accepts
    pulse_clear();
    press_key(4'd5, 200, 10);
    check("hold_stbs", 16'(stb_cnt), 16'd6);
    check("hold_digits", dig, 16'h0005);
    lock = 1'b1;
    press_key(4'd8, 10, 10);
    check("lock_stbs", 16'(stb_cnt), 16'd6);
    check("lock_digits", dig, 16'h0005);
    lock = 1'b0;
    press_key(4'd8, 10, 10);
    check("unlock_stbs", 16'(stb_cnt), 16'd7);
    check("unlock_digits", dig, 16'h0058);
    check("unlock_count", 16'(digit_count), 16'd2);

    // Non-decimal code is consumed without effect
    press_key(4'd12, 10, 10);
    check("nondec_stbs", 16'(stb_cnt), 16'd7);
    check("nondec_digits", dig, 16'h0058);

    // Fifth digit
    pulse_clear();
    press_key(4'd1, 10, 10);
    press_key(4'd2, 10, 10);
    press_key(4'd3, 10, 10);
    press_key(4'd4, 10, 10);
    check("full_digits", dig, 16'h1234);
    check("full_count", 16'(digit_count), 16'd4);
    press_key(4'd9, 10, 10);
    check("fifth_digits", dig, (RO != 0) ? 16'h2349 : 16'h1234);
    check("fifth_count", 16'(digit_count), 16'd4);
    check("fifth_stbs", 16'(stb_cnt), 16'(11 + RO));

    // Clear in the exact accept cycle of digit 6 (accept edge 7)
    pulse_clear();
    press_key(4'd1, 10, 10);
    check("pre_clr_digits", dig, 16'h0001);
    kp.D = 4'd6;
    kp.loadn = 1'b1;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clracc_digits", dig, 16'h0000);
    check("clracc_count", 16'(digit_count), 16'd0);
    check("clracc_stb", 16'(digit_stb), 16'd0);
    repeat (3) @(negedge clk);
    kp.loadn = 1'b0;
    repeat (10) @(negedge clk);
    check("clracc_stbs", 16'(stb_cnt), 16'(12 + RO));
    check("clracc_after", dig, 16'h0000);

    // Reset during PRESS_DB, loadn still high afterwards -> new press
    press_key(4'd4, 10, 10);
    check("prerst_digits", dig, 16'h0004);
    kp.D = 4'd5;
    kp.loadn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_digits", dig, 16'h0000);
    check("midrst_count", 16'(digit_count), 16'd0);
    check("midrst_stb", 16'(digit_stb), 16'd0);
    check("midrst_valid", 16'(entry_valid), 16'd0);
    check("midrst_state", 16'(dut.u_deb.state_r), 16'(IDLE));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    kp.loadn = 1'b0;
    repeat (10) @(negedge clk);
    check("postrst_digits", dig, 16'h0005);
    check("postrst_count", 16'(digit_count), 16'd1);
    check("postrst_stbs", 16'(stb_cnt), 16'(14 + RO));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
